// File: rtl/ct_mmu_jtlb_tag_ctrl.sv
// JTLB tag array access controller: request pipe, read return, invalidate-all sweep.
// Optional JTLB_RST_INV_EN: start an invalidate-all sweep automatically after reset.
`timescale 1ns/1ps
module ct_mmu_jtlb_tag_ctrl #(
  parameter int IDX_W = 8,
  parameter int TAG_W = 196
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst_b,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic             req_wr,
  input  logic [IDX_W-1:0] req_idx,
  input  logic [4:0]       req_way_wen,
  input  logic [TAG_W-1:0] req_din,
  input  logic             inv_all_req,
  output logic             inv_busy,
  output logic             inv_done,
  output logic             rd_data_vld,
  output logic [IDX_W-1:0] rd_idx,
  output logic [TAG_W-1:0] rd_data,
  output logic             jtlb_tag_cen,
  output logic [4:0]       jtlb_tag_wen,
  output logic [IDX_W-1:0] jtlb_tag_idx,
  output logic [TAG_W-1:0] jtlb_tag_din,
  input  logic [TAG_W-1:0] jtlb_tag_dout
);

  typedef enum logic {IDLE, SWEEP} state_e;

  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             cen_q, cen_d;
  logic [4:0]       wen_q, wen_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TAG_W-1:0] din_q, din_d;
  logic             rdp_q, rdp_d;
  logic             rvld_q;
  logic [IDX_W-1:0] ridx_q;
  logic             inv_start;
  logic             acc;

`ifdef JTLB_RST_INV_EN
  logic boot_q;

  // One-cycle flag after reset release that launches the boot sweep
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) boot_q <= 1'b1;
    else           boot_q <= 1'b0;
  end

  assign inv_start = inv_all_req | boot_q;
`else
  assign inv_start = inv_all_req;
`endif

  assign req_rdy = (state_q == IDLE) && !inv_start;
  assign acc     = req_vld && req_rdy;

  // Next state and next registered array inputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cen_d   = 1'b0;
    wen_d   = 5'h00;
    idx_d   = idx_q;
    din_d   = din_q;
    rdp_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (inv_start) begin
          state_d = SWEEP;
          cnt_d   = '0;
          cen_d   = 1'b1;
          wen_d   = 5'h1f;
          idx_d   = '0;
          din_d   = '0;
        end else if (acc) begin
          cen_d = 1'b1;
          idx_d = req_idx;
          if (req_wr) begin
            wen_d = req_way_wen;
            din_d = req_din;
          end else begin
            rdp_d = 1'b1;
          end
        end
      end
      SWEEP: begin
        if (cnt_q == IDX_MAX) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          cen_d = 1'b1;
          wen_d = 5'h1f;
          idx_d = cnt_q + 1'b1;
          din_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, sweep counter and array-facing registers
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cen_q   <= 1'b0;
      wen_q   <= 5'h00;
      idx_q   <= '0;
      din_q   <= '0;
      rdp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cen_q   <= cen_d;
      wen_q   <= wen_d;
      idx_q   <= idx_d;
      din_q   <= din_d;
      rdp_q   <= rdp_d;
    end
  end

  // Read return stage aligned with the array output latency
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rvld_q <= 1'b0;
      ridx_q <= '0;
    end else begin
      rvld_q <= rdp_q;
      if (rdp_q) ridx_q <= idx_q;
    end
  end

  assign jtlb_tag_cen = cen_q;
  assign jtlb_tag_wen = wen_q;
  assign jtlb_tag_idx = idx_q;
  assign jtlb_tag_din = din_q;
  assign inv_busy     = (state_q == SWEEP);
  assign inv_done     = (state_q == SWEEP) && (cnt_q == IDX_MAX);
  assign rd_data_vld  = rvld_q;
  assign rd_idx       = ridx_q;
  assign rd_data      = jtlb_tag_dout;

endmodule

// File: tb/tb_ct_mmu_jtlb_tag_ctrl.sv
// Directed bench for ct_mmu_jtlb_tag_ctrl with a behavioural tag array.
// Honors JTLB_RST_INV_EN for the post-reset expectations.
`timescale 1ns/1ps
module tb_ct_mmu_jtlb_tag_ctrl;

  logic         clk;
  logic         rst_n;
  logic         req_vld, req_rdy, req_wr;
  logic [7:0]   req_idx;
  logic [4:0]   req_way_wen;
  logic [195:0] req_din;
  logic         inv_all_req, inv_busy, inv_done;
  logic         rd_data_vld;
  logic [7:0]   rd_idx;
  logic [195:0] rd_data;
  logic         cen;
  logic [4:0]   wen;
  logic [7:0]   idx;
  logic [195:0] din, dout;

  int errors = 0;
  int checks = 0;

  ct_mmu_jtlb_tag_ctrl #(.IDX_W(8), .TAG_W(196)) dut (
    .forever_cpuclk(clk),
    .cpurst_b(rst_n),
    .req_vld(req_vld),
    .req_rdy(req_rdy),
    .req_wr(req_wr),
    .req_idx(req_idx),
    .req_way_wen(req_way_wen),
    .req_din(req_din),
    .inv_all_req(inv_all_req),
    .inv_busy(inv_busy),
    .inv_done(inv_done),
    .rd_data_vld(rd_data_vld),
    .rd_idx(rd_idx),
    .rd_data(rd_data),
    .jtlb_tag_cen(cen),
    .jtlb_tag_wen(wen),
    .jtlb_tag_idx(idx),
    .jtlb_tag_din(din),
    .jtlb_tag_dout(dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tag array: one-cycle read latency, per-field write enables
  logic [195:0] mem [256];
  logic [195:0] mask;
  always_comb mask = {{4{wen[4]}}, {48{wen[3]}}, {48{wen[2]}},
                      {48{wen[1]}}, {48{wen[0]}}};
  always @(posedge clk) begin
    if (cen) begin
      if (wen == 5'h00) dout <= mem[idx];
      else mem[idx] <= (mem[idx] & ~mask) | (din & mask);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [195:0] obs,
                     input logic [195:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [7:0] i,
                       input logic [4:0] we, input logic [195:0] d);
    req_vld     = v;
    req_wr      = w;
    req_idx     = i;
    req_way_wen = we;
    req_din     = d;
  endtask

  // Call in the first busy cycle; returns in the first idle cycle after
  task automatic sweep_watch(input string tag);
    int n, wr, done_at, rdy_bad;
    n = 0; wr = 0; done_at = -1; rdy_bad = 0;
    while (inv_busy && n < 300) begin
      if (cen && wen == 5'h1f && din == '0 && idx == n[7:0]) wr++;
      if (inv_done) done_at = n;
      if (req_rdy) rdy_bad++;
      n++;
      tick();
    end
    chk({tag, "_busy_cycles"}, n, 256);
    chk({tag, "_sweep_writes"}, wr, 256);
    chk({tag, "_done_at"}, done_at, 255);
    chk({tag, "_rdy_low"}, rdy_bad, 0);
  endtask

  logic [195:0] p0, pa, exp3c, ones;

  initial begin
    p0 = {4'h9, 48'h1111_2222_3333, 48'h4444_5555_6666,
          48'h7777_8888_9999, 48'haaaa_bbbb_cccc};
    pa = {4'h3, 48'ha0a0_a0a0_a0a0, 48'hb1b1_b1b1_b1b1,
          48'hc2c2_c2c2_c2c2, 48'hd3d3_d3d3_d3d3};
    exp3c = {p0[195:144], pa[143:96], p0[95:48], pa[47:0]};
    ones = '1;
    rst_n = 1'b0;
    inv_all_req = 1'b0;
    drive(0, 0, 8'h00, 5'h00, '0);
    repeat (3) tick();
    chk("rst_cen", cen, 0);
    chk("rst_wen", wen, 0);
    chk("rst_idx", idx, 0);
    chk("rst_din", din, 0);
    chk("rst_rvld", rd_data_vld, 0);
    chk("rst_ridx", rd_idx, 0);
    chk("rst_busy", inv_busy, 0);
    chk("rst_done", inv_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
`ifdef JTLB_RST_INV_EN
    chk("boot_busy", inv_busy, 1);
    sweep_watch("boot");
`else
    chk("boot_rdy", req_rdy, 1);
    chk("boot_busy", inv_busy, 0);
`endif

    drive(1, 1, 8'h3c, 5'h1f, p0);
    #1 chk("wr0_rdy", req_rdy, 1);
    tick();
    chk("wr0_cen", cen, 1);
    chk("wr0_wen", wen, 5'h1f);
    chk("wr0_idx", idx, 8'h3c);
    chk("wr0_din", din, p0);
    drive(1, 1, 8'h3c, 5'b00101, pa);
    tick();
    chk("wrA_wen", wen, 5'b00101);
    chk("wrA_din", din, pa);
    drive(1, 0, 8'h3c, 5'h1f, '0);
    tick();
    chk("rd_cen", cen, 1);
    chk("rd_wen", wen, 0);
    drive(0, 0, 8'h00, 5'h00, '0);
    tick();
    chk("rd_vld", rd_data_vld, 1);
    chk("rd_idx", rd_idx, 8'h3c);
    chk("rd_data", rd_data, exp3c);
    chk("idle_cen", cen, 0);
    tick();
    chk("rd_vld_drop", rd_data_vld, 0);
    chk("idle_idx_hold", idx, 8'h3c);
    chk("idle_din_hold", din, pa);

    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1, 0, 8'(i + 1), 5'h00, '0);
      else drive(0, 0, 8'h00, 5'h00, '0);
      tick();
      chk($sformatf("b2b_vld%0d", i), rd_data_vld, (i >= 1 && i <= 4));
      if (i >= 1 && i <= 4) chk($sformatf("b2b_idx%0d", i), rd_idx, i);
    end

    drive(1, 1, 8'h3c, 5'h00, ones);
    tick();
    chk("w0_cen", cen, 1);
    chk("w0_wen", wen, 0);
    drive(0, 0, 8'h00, 5'h00, '0);
    tick();
    chk("w0_cen_off", cen, 0);
    chk("w0_norsp1", rd_data_vld, 0);
    tick();
    chk("w0_norsp2", rd_data_vld, 0);
    drive(1, 0, 8'h3c, 5'h00, '0);
    tick();
    drive(0, 0, 8'h00, 5'h00, '0);
    tick();
    chk("w0_unchanged", rd_data, exp3c);

    drive(1, 1, 8'h00, 5'h1f, p0);
    tick();
    drive(1, 1, 8'hff, 5'h1f, pa);
    tick();
    drive(1, 0, 8'hff, 5'h00, '0);
    inv_all_req = 1'b1;
    #1 chk("coll_rdy", req_rdy, 0);
    tick();
    inv_all_req = 1'b0;
    chk("inv_busy", inv_busy, 1);
    sweep_watch("inv");
    chk("held_rdy", req_rdy, 1);
    tick();
    drive(0, 0, 8'h00, 5'h00, '0);
    chk("held_cen", cen, 1);
    chk("held_wen", wen, 0);
    chk("held_idx", idx, 8'hff);
    tick();
    chk("inv_rvld", rd_data_vld, 1);
    chk("inv_ridx", rd_idx, 8'hff);
    chk("inv_rd255", rd_data, 0);
    drive(1, 0, 8'h00, 5'h00, '0);
    tick();
    drive(0, 0, 8'h00, 5'h00, '0);
    tick();
    chk("inv_rd0", rd_data, 0);

    inv_all_req = 1'b1;
    tick();
    inv_all_req = 1'b0;
    for (int k = 0; k < 300 && idx != 8'd100; k++) tick();
    chk("mid_idx", idx, 8'd100);
    rst_n = 1'b0;
    #1;
    chk("mid_cen", cen, 0);
    chk("mid_wen", wen, 0);
    chk("mid_idx0", idx, 0);
    chk("mid_din", din, 0);
    chk("mid_busy", inv_busy, 0);
    chk("mid_done", inv_done, 0);
    chk("mid_rvld", rd_data_vld, 0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
`ifdef JTLB_RST_INV_EN
    chk("mid_restart", inv_busy, 1);
    sweep_watch("mid");
`else
    chk("mid_rdy", req_rdy, 1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mid_nodone%0d", k), inv_done, 0);
      chk($sformatf("mid_nocen%0d", k), cen, 0);
      tick();
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ct_mmu_jtlb_tag_ctrl.md
# ct_mmu_jtlb_tag_ctrl

Access controller on the requester side of the JTLB tag array. It accepts single-entry read and write requests from the MMU lookup/refill logic and drives the array's enable, way-write-enable, index and data inputs. It returns read data after the one-cycle array latency. It also runs a 256-entry invalidate-all sweep that zeroes every way and the FIFO field. It sits between the JTLB control logic and the tag array wrapper, and drives the array's clock-gate enable through `jtlb_tag_cen`.

## Interface
Parameters:
- `IDX_W`, 8, index width; the array holds 2^IDX_W entries.
- `TAG_W`, 196, entry width: FIFO[195:192], way3[191:144], way2[143:96], way1[95:48], way0[47:0].

Ports:
- `forever_cpuclk` in 1: the block's single clock.
- `cpurst_b` in 1: asynchronous, active-low reset.
- `req_vld` in 1: an access request is valid.
- `req_rdy` out 1: the request is accepted when `req_vld && req_rdy`.
- `req_wr` in 1: 1 = write, 0 = read.
- `req_idx` in IDX_W: entry index.
- `req_way_wen` in 5: per-field write enable, bit4 = FIFO, bits3..0 = way3..way0. Ignored on reads.
- `req_din` in TAG_W: write data.
- `inv_all_req` in 1: single-cycle pulse that starts the invalidate-all sweep.
- `inv_busy` out 1: the sweep is in progress.
- `inv_done` out 1: single-cycle pulse on the final sweep write.
- `rd_data_vld` out 1: read data is valid.
- `rd_idx` out IDX_W: index of the returned read.
- `rd_data` out TAG_W: read data.
- `jtlb_tag_cen` out 1: array enable, active high.
- `jtlb_tag_wen` out 5: array field write enables.
- `jtlb_tag_idx` out IDX_W: array index.
- `jtlb_tag_din` out TAG_W: array write data.
- `jtlb_tag_dout` in TAG_W: array read data, valid one cycle after the enable cycle.

## Operation
- FSM states: IDLE and SWEEP.
  - IDLE → SWEEP on `inv_all_req`.
  - SWEEP → IDLE after the write to index 2^IDX_W−1.
- `req_rdy = (state==IDLE) && !inv_all_req`, so `inv_all_req` beats a simultaneous request. That request is not accepted and the requester must hold it.
- Accepted read: registered outputs `cen=1`, `wen=0`, `idx=req_idx`. A read tag pipe (vld, idx) follows it.
- Accepted write: `cen=1`, `wen=req_way_wen`, `idx=req_idx`, `din=req_din`. No response is returned.
  - A write with `req_way_wen==0` asserts `cen` only. No data changes and no response is returned.
- Cycles with no accepted request and no sweep: `cen=0`, `wen=0`. `idx` and `din` hold their last value.
- SWEEP, one write per cycle with an IDX_W-bit counter running 0 → 2^IDX_W−1:
  - `cen=1`, `wen=5'h1f`, `din=0`, `idx=counter`.
  - The counter resets to 0 on SWEEP entry and does not wrap.
- `inv_all_req` during SWEEP is ignored. This is safe because no writes are accepted during the sweep.
- A read accepted in the cycle before `inv_all_req` still returns its data normally.
- All outputs reset to 0. The counter and read pipe also reset to 0.

## Timing
- Request accepted in cycle T:
  - Array inputs are driven in T+1.
  - The array samples them at the end of T+1.
  - For a read, `rd_data_vld=1` and `rd_idx=idx` in T+2, with `rd_data = jtlb_tag_dout` passed through combinationally.
- Throughput is one request per cycle. Back-to-back reads produce back-to-back `rd_data_vld`.
- `inv_all_req` in cycle T:
  - `inv_busy` is high T+1..T+2^IDX_W.
  - Sweep writes occur in T+1..T+2^IDX_W.
  - `inv_done` pulses in T+2^IDX_W.
  - `req_rdy` returns to 1 in T+2^IDX_W+1.
- `cpurst_b` asserted mid-sweep: immediately IDLE, counter 0, `cen=0`, and any pending read response is dropped.

## Configuration
- `JTLB_RST_INV_EN` defined: on release of `cpurst_b`, the FSM enters SWEEP automatically in the first clock, exactly as if `inv_all_req` had pulsed.
  - `req_rdy=0` and `inv_busy=1` until the sweep completes.
  - `inv_done` pulses at the end of the sweep.
- Not defined: the FSM leaves reset in IDLE with `req_rdy=1`. Array contents are undefined until software or `inv_all_req` invalidates them.

## Test plan
- Write idx 0x3C, wen 5'b00101, din pattern A; then read 0x3C → in T+2, `rd_data_vld=1`, `rd_idx=0x3C`, way0/way2 fields equal A, other fields hold their prior value.
- Four back-to-back reads of idx 1,2,3,4 → `rd_data_vld` high four consecutive cycles, `rd_idx` 1,2,3,4 in order.
- Fill idx 0 and idx 255 with nonzero data, pulse `inv_all_req` → exactly 256 cycles of `cen=1`/`wen=5'h1f`, `inv_done` on the idx=255 write, later reads of 0 and 255 return all zeros.
- `req_vld` and `inv_all_req` in the same IDLE cycle → `req_rdy=0`, the sweep starts, and the held request is accepted in the first cycle after the sweep.
- Assert `cpurst_b` low at sweep index 100 → all outputs 0 and `inv_done` never pulses. Without the macro, `req_rdy=1` after release; with `JTLB_RST_INV_EN`, a full 256-cycle sweep restarts from 0.
- Write with `req_wr=1`, `req_way_wen=0` → `cen=1`, `wen=0` for one cycle, no `rd_data_vld`, array unchanged on readback.
